// File: rtl/ras_mem_arbiter.sv
// Shared data-memory port arbiter between the core load/store path and the
// CRAS spill/fill engine. One transaction at a time: grant in IDLE, hold the
// memory request in BUSY_x until mem_ack or timeout, then pulse the winner's ack.
module ras_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          Rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [3:0]    core_be,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_hold,
  input  logic          ras_req,
  input  logic          ras_we,
  input  logic [AW-1:0] ras_addr,
  input  logic [DW-1:0] ras_wdata,
  input  logic          ras_urgent,
  output logic [DW-1:0] ras_rdata,
  output logic          ras_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          err_clr,
  output logic          timeout_err,
  output logic          busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {StIdle, StBusyCore, StBusyRas, StResp} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            last_ras_q, last_ras_d;   // 1: previous grant went to RAS
  logic            grant_ras_q, grant_ras_d; // requester currently being served
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   core_rdata_q, core_rdata_d;
  logic [DW-1:0]   ras_rdata_q, ras_rdata_d;
  logic            timeout_err_q, timeout_err_d;
  logic            grant_core, grant_ras, tmo_hit;

  // Arbitration, transaction sequencing and timeout bookkeeping.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    starve_d      = starve_q;
    last_ras_d    = last_ras_q;
    grant_ras_d   = grant_ras_q;
    mem_we_d      = mem_we_q;
    mem_be_d      = mem_be_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    core_rdata_d  = core_rdata_q;
    ras_rdata_d   = ras_rdata_q;
    grant_core    = 1'b0;
    grant_ras     = 1'b0;
    tmo_hit       = 1'b0;

    case (state_q)
      StIdle: begin
        if (core_req && ras_req) begin
          // Urgent RAS wins until the core has been starved MAX_STARVE times.
          if (ras_urgent && (starve_q < SW'(MAX_STARVE))) begin
            grant_ras = 1'b1;
          end else if (starve_q == SW'(MAX_STARVE)) begin
            grant_core = 1'b1;
          end else if (last_ras_q) begin
            grant_core = 1'b1;
          end else begin
            grant_ras = 1'b1;
          end
        end else if (core_req) begin
          grant_core = 1'b1;
        end else if (ras_req) begin
          grant_ras = 1'b1;
        end

        if (grant_core) begin
          state_d     = StBusyCore;
          grant_ras_d = 1'b0;
          mem_we_d    = core_we;
          mem_be_d    = core_be;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
          starve_d    = '0;
        end else if (grant_ras) begin
          state_d     = StBusyRas;
          grant_ras_d = 1'b1;
          mem_we_d    = ras_we;
          mem_be_d    = 4'hF;
          mem_addr_d  = ras_addr;
          mem_wdata_d = ras_wdata;
          if (core_req && (starve_q != SW'(MAX_STARVE))) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      StBusyCore, StBusyRas: begin
        if (mem_ack) begin
          state_d = StResp;
          if (state_q == StBusyCore) core_rdata_d = mem_rdata;
          else                       ras_rdata_d  = mem_rdata;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT-th waiting cycle without an ack: abort with zero data.
          tmo_hit = 1'b1;
          state_d = StResp;
          if (state_q == StBusyCore) core_rdata_d = '0;
          else                       ras_rdata_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StResp: begin
        last_ras_d = grant_ras_q;
        tmo_d      = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new timeout takes priority over a simultaneous clear.
    if (tmo_hit)      timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
    else              timeout_err_d = timeout_err_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= StIdle;
      tmo_q         <= '0;
      starve_q      <= '0;
      last_ras_q    <= 1'b1;
      grant_ras_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= 4'h0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      core_rdata_q  <= '0;
      ras_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      starve_q      <= starve_d;
      last_ras_q    <= last_ras_d;
      grant_ras_q   <= grant_ras_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      core_rdata_q  <= core_rdata_d;
      ras_rdata_q   <= ras_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Output decode; core_hold is forced low while reset is asserted.
  always_comb begin
    mem_req     = (state_q == StBusyCore) || (state_q == StBusyRas);
    core_ack    = (state_q == StResp) && !grant_ras_q;
    ras_ack     = (state_q == StResp) && grant_ras_q;
    busy        = (state_q != StIdle);
    core_hold   = Rst_n && core_req && !core_ack;
    mem_we      = mem_we_q;
    mem_be      = mem_be_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    core_rdata  = core_rdata_q;
    ras_rdata   = ras_rdata_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_ras_mem_arbiter.sv
// Self-checking bench for ras_mem_arbiter: scenario tasks with a scoreboard of
// expected (requester, rdata) completions and a behavioural memory responder.
module tb_ras_mem_arbiter;

  logic        clk;
  logic        Rst_n;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ack, core_hold;
  logic        ras_req, ras_we, ras_urgent;
  logic [31:0] ras_addr, ras_wdata, ras_rdata;
  logic        ras_ack;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        err_clr, timeout_err, busy;

  typedef struct packed {
    logic        is_ras;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mem_delay = 0;
  bit   mem_en = 1'b1;

  ras_mem_arbiter dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ack   (core_ack),
    .core_hold  (core_hold),
    .ras_req    (ras_req),
    .ras_we     (ras_we),
    .ras_addr   (ras_addr),
    .ras_wdata  (ras_wdata),
    .ras_urgent (ras_urgent),
    .ras_rdata  (ras_rdata),
    .ras_ack    (ras_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err_clr    (err_clr),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEF00D;
    return (a ^ 32'h5A5A_0000) + 32'd1;
  endfunction

  // Memory: acks mem_delay cycles after the first cycle mem_req is seen high.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && mem_en) begin
        cnt++;
        if (cnt == mem_delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end
      end else if (!mem_req) begin
        cnt = 0;
      end
    end
  end

  task automatic wait_ack(output bit got, output bit is_ras, output logic [31:0] rd);
    got = 1'b0;
    is_ras = 1'b0;
    rd = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (core_ack || ras_ack) begin
        got = 1'b1;
        is_ras = ras_ack;
        rd = ras_ack ? ras_rdata : core_rdata;
        break;
      end
    end
  endtask

  task automatic push_exp(input bit is_ras, input logic [31:0] rd);
    exp_t e;
    e.is_ras = is_ras;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_be = 4'h0; core_addr = '0; core_wdata = '0;
    ras_req = 1'b0; ras_we = 1'b0; ras_addr = '0; ras_wdata = '0; ras_urgent = 1'b0;
    err_clr = 1'b0;
    #3;
    n_tests++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({core_ack, core_hold, core_rdata, ras_ack, ras_rdata, timeout_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_req: got cack=%b hold=%b crd=%h rack=%b rrd=%h err=%b busy=%b, want 0",
               core_ack, core_hold, core_rdata, ras_ack, ras_rdata, timeout_err, busy);
    end
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    bit got, is_ras;
    logic [31:0] rd;
    exp_t e;
    mem_delay = 0;
    core_addr = 32'h40; core_we = 1'b0; core_be = 4'hF; core_wdata = 32'h1111;
    ras_addr = 32'h9000; ras_we = 1'b0; ras_urgent = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(i[0], i[0] ? mem_model(32'h9000) : mem_model(32'h40));
    @(negedge clk);
    core_req = 1'b1;
    ras_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(got, is_ras, rd);
      n_tests++;
      if (!got || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got ack=%0d, want an ack", i, got);
      end else begin
        e = exp_q.pop_front();
        if (is_ras !== e.is_ras || rd !== e.rdata) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got ras=%0d rdata=%h, want ras=%0d rdata=%h",
                   i, is_ras, rd, e.is_ras, e.rdata);
        end
      end
      if (i == 3) begin core_req = 1'b0; ras_req = 1'b0; end
    end
  endtask

  task automatic test_core_read();
    bit [5:0] exp_mreq, exp_ack, exp_hold;
    exp_t e;
    exp_mreq = 6'b001110;
    exp_ack  = 6'b010000;
    exp_hold = 6'b001111;
    mem_delay = 2;
    core_addr = 32'h100; core_we = 1'b0; core_be = 4'h3; core_wdata = 32'h0;
    push_exp(1'b0, 32'hCAFEF00D);
    @(negedge clk);
    core_req = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      n_tests++;
      if (mem_req !== exp_mreq[c] || core_ack !== exp_ack[c] || core_hold !== exp_hold[c]) begin
        n_fail++;
        $display("FAIL core_read_c%0d: got mem_req=%b ack=%b hold=%b, want %b %b %b", c,
                 mem_req, core_ack, core_hold, exp_mreq[c], exp_ack[c], exp_hold[c]);
      end
      if (c == 1) begin
        n_tests++;
        if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'h3, 32'h100}) begin
          n_fail++;
          $display("FAIL core_read_cmd: got we=%b be=%h addr=%h, want 0 3 00000100",
                   mem_we, mem_be, mem_addr);
        end
      end
      if (core_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (e.is_ras !== 1'b0 || core_rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL core_read_data: got %h, want %h", core_rdata, e.rdata);
        end
      end
      if (c == 4) core_req = 1'b0;
    end
  endtask

  task automatic test_urgent();
    bit got, is_ras;
    logic [31:0] rd;
    exp_t e;
    mem_delay = 0;
    core_addr = 32'h300; core_be = 4'hF; core_we = 1'b0;
    ras_addr = 32'h8100; ras_we = 1'b0; ras_urgent = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push_exp(1'b0, mem_model(32'h300));
      else                  push_exp(1'b1, mem_model(32'h8100));
    end
    @(negedge clk);
    core_req = 1'b1;
    ras_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_ack(got, is_ras, rd);
      n_tests++;
      if (!got || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL urgent_grant%0d: got ack=%0d, want an ack", i, got);
      end else begin
        e = exp_q.pop_front();
        if (is_ras !== e.is_ras || rd !== e.rdata) begin
          n_fail++;
          $display("FAIL urgent_grant%0d: got ras=%0d rdata=%h, want ras=%0d rdata=%h",
                   i, is_ras, rd, e.is_ras, e.rdata);
        end
      end
      if (i == 9) begin core_req = 1'b0; ras_req = 1'b0; ras_urgent = 1'b0; end
    end
  endtask

  task automatic test_spill();
    int acks, busy_cyc;
    exp_t e;
    acks = 0;
    busy_cyc = 0;
    mem_delay = 3;
    ras_we = 1'b1; ras_addr = 32'h8000; ras_wdata = 32'h1234;
    push_exp(1'b1, mem_model(32'h8000));
    @(negedge clk);
    ras_req = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (mem_req) begin
        busy_cyc++;
        n_tests++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h8000, 32'h1234}) begin
          n_fail++;
          $display("FAIL spill_cmd: got we=%b be=%h addr=%h wdata=%h, want 1 f 00008000 00001234",
                   mem_we, mem_be, mem_addr, mem_wdata);
        end
        // Requester inputs wander mid-transaction; the memory command must not.
        if (busy_cyc == 2) begin ras_addr = 32'hDEAD0000; ras_wdata = 32'hFFFF; end
      end
      if (ras_ack) begin
        acks++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (e.is_ras !== 1'b1 || ras_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL spill_data: got %h, want %h", ras_rdata, e.rdata);
          end
        end
        ras_req = 1'b0;
      end
    end
    n_tests++;
    if (acks != 1 || busy_cyc != 4) begin
      n_fail++;
      $display("FAIL spill_pulse: got acks=%0d busy=%0d, want 1 and 4", acks, busy_cyc);
    end
    ras_we = 1'b0;
  endtask

  task automatic run_timeout(input bit clr_last, output int n);
    exp_t e;
    n = 0;
    core_addr = 32'h200; core_we = 1'b0; core_be = 4'hF;
    push_exp(1'b0, 32'h0);
    @(negedge clk);
    core_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (core_ack) begin
        err_clr = 1'b0;
        core_req = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (e.is_ras !== 1'b0 || core_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL timeout_data: got %h, want %h", core_rdata, e.rdata);
          end
        end
        break;
      end
      if (mem_req) n++;
      if (clr_last && n == 255) err_clr = 1'b1;
    end
    err_clr = 1'b0;
    core_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    mem_en = 1'b0;
    run_timeout(1'b0, n);
    n_tests++;
    if (n != 255 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout1: got req_cycles=%0d err=%b, want 255 1", n, timeout_err);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%b, want 1", timeout_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clr: got err=%b, want 0", timeout_err);
    end
    run_timeout(1'b1, n);
    n_tests++;
    if (n != 255 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_set_wins: got req_cycles=%0d err=%b, want 255 1", n, timeout_err);
    end
    mem_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit got, is_ras;
    logic [31:0] rd;
    exp_t e;
    mem_en = 1'b0;
    ras_addr = 32'h8200; ras_we = 1'b0; ras_urgent = 1'b0;
    core_addr = 32'h300; core_we = 1'b0; core_be = 4'hF;
    @(negedge clk);
    ras_req = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got mem_req=%b busy=%b, want 1 1", mem_req, busy);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, ras_ack, busy, timeout_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got mem_req=%b ras_ack=%b busy=%b err=%b, want 0 0 0 0",
               mem_req, ras_ack, busy, timeout_err);
    end
    core_req = 1'b1;
    #1;
    n_tests++;
    if (core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got core_hold=%b, want 0", core_hold);
    end
    mem_en = 1'b1;
    mem_delay = 0;
    push_exp(1'b0, mem_model(32'h300));
    push_exp(1'b1, mem_model(32'h8200));
    repeat (2) @(negedge clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_ack(got, is_ras, rd);
      n_tests++;
      if (!got || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL post_reset%0d: got ack=%0d, want an ack", i, got);
      end else begin
        e = exp_q.pop_front();
        if (is_ras !== e.is_ras || rd !== e.rdata) begin
          n_fail++;
          $display("FAIL post_reset%0d: got ras=%0d rdata=%h, want ras=%0d rdata=%h",
                   i, is_ras, rd, e.is_ras, e.rdata);
        end
      end
      if (got && !is_ras) core_req = 1'b0;
      if (got && is_ras)  ras_req = 1'b0;
    end
    core_req = 1'b0;
    ras_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_core_read();
    test_urgent();
    test_spill();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
